ifetch_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and drives the

---
 rtl/ifetch_unit_pkg.sv | 29 ++
 rtl/ifetch_unit_if.sv | 27 ++
 rtl/ifetch_unit_ifid.sv | 34 +++
 rtl/ifetch_unit.sv | 60 ++++++
 tb/tb_ifetch_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
// Holds the text window, IF/ID record layout and the fetch address checker.
package ifetch_unit_pkg;

  localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
  localparam int          IMEM_DEPTH = 4096;
  localparam int          IMEM_AW    = 12;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        exc;
  } ifid_t;

  // 33-bit offset keeps PCs below the base from wrapping into the legal window.
  function automatic logic fetch_err_f(input logic [31:0] pc, input logic [31:0] base,
                                       input int depth);
    logic [32:0] off;
    logic [32:0] limit;
    off   = {1'b0, pc} - {1'b0, base};
    limit = 33'(depth) << 2;
    return (pc[1:0] != 2'b00) | off[32] | (off >= limit);
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: hazard/EX controls in, IMem port, PC and IF/ID record out.
// master = fetch unit, slave = surrounding pipeline and IMem.
interface ifetch_unit_if
  import ifetch_unit_pkg::*;
  ();
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_instr;
  logic [31:0]        pc;
  logic               if_id_valid;
  logic [31:0]        if_id_instr;
  logic [31:0]        if_id_pc;
  logic [31:0]        if_id_pc4;
  logic               if_id_exc;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, if_id_exc
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, if_id_exc
  );
endinterface

// File: rtl/ifetch_unit_ifid.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module ifid_reg
  import ifetch_unit_pkg::*;
  (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  hold_i,
  input  ifid_t load_i,
  output ifid_t ifid_o
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, exc: 1'b0};
    end else if (!hold_i) begin
      ifid_d = load_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, AdEL detection
// and IF/ID capture of the combinational IMem read data.
module ifetch_unit
  import ifetch_unit_pkg::*;
  (
  input logic           clk,
  input logic           rst_n,
  ifetch_unit_if.master fif
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        fetch_err;
  ifid_t       load, ifid_q;

  assign pc_plus4  = pc_q + 32'd4;
  assign fetch_err = fetch_err_f(pc_q, TEXT_BASE, IMEM_DEPTH);

  // A redirect beats a stall: the younger fetch is squashed either way.
  always_comb begin
    pc_d = pc_q;
    if (fif.redirect) begin
      pc_d = fif.redirect_pc;
    end else if (!fif.stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= TEXT_BASE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign fif.imem_addr = pc_q[IMEM_AW+1:2] - TEXT_BASE[IMEM_AW+1:2];

  assign load = '{valid: 1'b1,
                  instr: fetch_err ? NOP_INSTR : fif.imem_instr,
                  pc:    pc_q,
                  pc4:   pc_plus4,
                  exc:   fetch_err};

  ifid_reg u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fif.redirect),
    .hold_i  (fif.stall),
    .load_i  (load),
    .ifid_o  (ifid_q)
  );

  assign fif.pc          = pc_q;
  assign fif.if_id_valid = ifid_q.valid;
  assign fif.if_id_instr = ifid_q.instr;
  assign fif.if_id_pc    = ifid_q.pc;
  assign fif.if_id_pc4   = ifid_q.pc4;
  assign fif.if_id_exc   = ifid_q.exc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural IMem holding 0x1000_0001 + word index.
module tb_ifetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] mem [0:4095];

  ifetch_unit_if fif ();

  ifetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif.master)
  );

  assign fif.imem_instr = mem[fif.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fif.stall = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = 32'h0;
    rst_n = 1'b0;
    #12;
    checks++; if (fif.pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want 00003000", fif.pc); end
    checks++; if (fif.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fif.if_id_valid); end
    checks++; if ({fif.if_id_instr, fif.if_id_pc, fif.if_id_pc4, fif.if_id_exc} !== 97'h0) begin
      errors++; $display("FAIL reset_ifid: got %h %h %h %b want zeros", fif.if_id_instr, fif.if_id_pc, fif.if_id_pc4, fif.if_id_exc);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      p = 32'h3000 + 32'(4 * i);
      checks++; if (fif.if_id_pc !== p) begin errors++; $display("FAIL run_pc[%0d]: got %h want %h", i, fif.if_id_pc, p); end
      checks++; if (fif.if_id_pc4 !== p + 32'd4) begin errors++; $display("FAIL run_pc4[%0d]: got %h want %h", i, fif.if_id_pc4, p + 32'd4); end
      checks++; if (fif.if_id_instr !== 32'h1000_0001 + 32'(i)) begin errors++; $display("FAIL run_instr[%0d]: got %h want %h", i, fif.if_id_instr, 32'h1000_0001 + 32'(i)); end
      checks++; if ({fif.if_id_valid, fif.if_id_exc} !== 2'b10) begin errors++; $display("FAIL run_flags[%0d]: got %b%b want 10", i, fif.if_id_valid, fif.if_id_exc); end
      checks++; if (fif.pc !== p + 32'd4) begin errors++; $display("FAIL run_next_pc[%0d]: got %h want %h", i, fif.pc, p + 32'd4); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fif.pc !== 32'h3008) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 00003008", i, fif.pc); end
      checks++; if (fif.if_id_pc !== 32'h3004 || fif.if_id_instr !== 32'h1000_0002 || fif.if_id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h %h %b want 00003004 10000002 1", i, fif.if_id_pc, fif.if_id_instr, fif.if_id_valid);
      end
    end
    fif.stall = 1'b0;
    step();
    checks++; if (fif.if_id_pc !== 32'h3008 || fif.if_id_instr !== 32'h1000_0003) begin
      errors++; $display("FAIL stall_release: got %h %h want 00003008 10000003", fif.if_id_pc, fif.if_id_instr);
    end
    step();
    checks++; if (fif.if_id_pc !== 32'h300C || fif.pc !== 32'h3010) begin
      errors++; $display("FAIL stall_once: got %h pc %h want 0000300c pc 00003010", fif.if_id_pc, fif.pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step(); step();
    checks++; if (fif.pc !== 32'h300C) begin errors++; $display("FAIL redir_setup: got %h want 0000300c", fif.pc); end
    fif.redirect = 1'b1; fif.redirect_pc = 32'h3040;
    step();
    fif.redirect = 1'b0;
    checks++; if (fif.pc !== 32'h3040) begin errors++; $display("FAIL redir_pc: got %h want 00003040", fif.pc); end
    checks++; if ({fif.if_id_valid, fif.if_id_instr, fif.if_id_pc, fif.if_id_pc4, fif.if_id_exc} !== 98'h0) begin
      errors++; $display("FAIL redir_bubble: got %b %h %h %h %b want zeros", fif.if_id_valid, fif.if_id_instr, fif.if_id_pc, fif.if_id_pc4, fif.if_id_exc);
    end
    step();
    checks++; if (fif.if_id_pc !== 32'h3040 || fif.if_id_pc4 !== 32'h3044 || fif.if_id_instr !== 32'h1000_0011 || fif.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL redir_target: got %h %h %h %b want 00003040 00003044 10000011 1", fif.if_id_pc, fif.if_id_pc4, fif.if_id_instr, fif.if_id_valid);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    step(); step();
    fif.stall = 1'b1; fif.redirect = 1'b1; fif.redirect_pc = 32'h3100;
    step();
    fif.stall = 1'b0; fif.redirect = 1'b0;
    checks++; if (fif.pc !== 32'h3100) begin errors++; $display("FAIL rs_pc: got %h want 00003100", fif.pc); end
    checks++; if (fif.if_id_valid !== 1'b0 || fif.if_id_instr !== 32'h0 || fif.if_id_pc !== 32'h0) begin
      errors++; $display("FAIL rs_bubble: got %b %h %h want 0 0 0", fif.if_id_valid, fif.if_id_instr, fif.if_id_pc);
    end
    step();
    checks++; if (fif.if_id_pc !== 32'h3100 || fif.if_id_instr !== 32'h1000_0041) begin
      errors++; $display("FAIL rs_target: got %h %h want 00003100 10000041", fif.if_id_pc, fif.if_id_instr);
    end
  endtask

  task automatic test_adel();
    logic [31:0] bad   [5];
    logic        exp_e [5];
    logic [31:0] exp_i [5];
    bad[0] = 32'h3002;      exp_e[0] = 1'b1; exp_i[0] = 32'h0;
    bad[1] = 32'h2FFC;      exp_e[1] = 1'b1; exp_i[1] = 32'h0;
    bad[2] = 32'h7000;      exp_e[2] = 1'b1; exp_i[2] = 32'h0;
    bad[3] = 32'h6FFC;      exp_e[3] = 1'b0; exp_i[3] = 32'h1000_1000;
    bad[4] = 32'hFFFF_FFFC; exp_e[4] = 1'b1; exp_i[4] = 32'h0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fif.redirect = 1'b1; fif.redirect_pc = bad[i];
      step();
      fif.redirect = 1'b0;
      step();
      checks++; if (fif.if_id_exc !== exp_e[i] || fif.if_id_valid !== 1'b1) begin
        errors++; $display("FAIL adel_exc[%0d]: got exc %b valid %b want exc %b valid 1", i, fif.if_id_exc, fif.if_id_valid, exp_e[i]);
      end
      checks++; if (fif.if_id_instr !== exp_i[i] || fif.if_id_pc !== bad[i]) begin
        errors++; $display("FAIL adel_data[%0d]: got %h @%h want %h @%h", i, fif.if_id_instr, fif.if_id_pc, exp_i[i], bad[i]);
      end
      checks++; if (fif.pc !== bad[i] + 32'd4) begin errors++; $display("FAIL adel_seq[%0d]: got %h want %h", i, fif.pc, bad[i] + 32'd4); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (fif.pc !== 32'h3000 || fif.if_id_valid !== 1'b0 || fif.if_id_pc !== 32'h0) begin
      errors++; $display("FAIL async_rst: got pc %h valid %b ifpc %h want 00003000 0 0", fif.pc, fif.if_id_valid, fif.if_id_pc);
    end
    #7;
    rst_n = 1'b1;
    step();
    checks++; if (fif.if_id_pc !== 32'h3000 || fif.if_id_instr !== 32'h1000_0001 || fif.if_id_valid !== 1'b1 || fif.pc !== 32'h3004) begin
      errors++; $display("FAIL async_restart: got %h %h %b pc %h want 00003000 10000001 1 00003004", fif.if_id_pc, fif.if_id_instr, fif.if_id_valid, fif.pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0001 + 32'(i);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_adel();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
